neuron_mac: RTL and testbench

Sequencing multiply-accumulate stage that sits directly downstream of one weight-ROM column. It sweeps the 5-bit weight address and multiplies each registered Q6.7 weight by the matching activation from the activation buffer. Products are summed on top of a bias, then rounded and saturated back to Q6.7, with optional ReLU. The result is presented with a one-cycle valid pulse to the next layer's activation buffer.

---
 rtl/neuron_mac.sv | 130 +++++++++++++
 tb/tb_neuron_mac.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - sequenced Q6.7 multiply-accumulate over one weight-ROM column
// Products sum on top of a bias, then round half-up, saturate and optionally ReLU.
module neuron_mac #(
  parameter int INT_BITS = 6,
  parameter int FRC_BITS = 7,
  parameter int N_INPUTS = 28,
  parameter bit RELU     = 1'b1,
  localparam int W       = INT_BITS + FRC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bias,
  output logic [4:0]   addr,
  input  logic [W-1:0] w_in,
  input  logic [W-1:0] x_in,
  output logic         busy,
  output logic [W-1:0] y,
  output logic         y_valid
);

  localparam int PW = 2 * W;
  localparam int AW = PW + $clog2(N_INPUTS) + 1;
  localparam logic [4:0] LAST = 5'(N_INPUTS - 1);
  localparam logic signed [AW-1:0] HALF = {{(AW-FRC_BITS){1'b0}}, 1'b1, {(FRC_BITS-1){1'b0}}};
  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ROUND} state_t;

  state_t               state_q, state_d;
  logic [4:0]           addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 v_q, v_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [W-1:0]         y_q, y_d;
  logic                 y_valid_q, y_valid_d;

  logic signed [PW-1:0] w_ext, x_ext, prod;
  logic signed [AW-1:0] prod_ext, bias_ext, rnd_sum, r_full;
  logic [W-1:0]         y_sat;

  assign w_ext    = {{W{w_in[W-1]}}, w_in};
  assign x_ext    = {{W{x_in[W-1]}}, x_in};
  assign prod     = w_ext * x_ext;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(AW-W){bias[W-1]}}, bias};

  // Accumulator carries 2*FRC_BITS fraction bits; drop FRC_BITS with half-up rounding.
  always_comb begin
    rnd_sum = acc_q + HALF;
    r_full  = rnd_sum >>> FRC_BITS;
    if (r_full > MAXV) begin
      y_sat = MAXV[W-1:0];
    end else if (r_full < MINV) begin
      y_sat = MINV[W-1:0];
    end else begin
      y_sat = r_full[W-1:0];
    end
    if (RELU && r_full[AW-1]) begin
      y_sat = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    // v marks the cycle in which the ROM response for an issued address is present.
    v_d       = (state_q == S_RUN);
    if (v_q) begin
      acc_d = acc_q + prod_ext;
    end
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        busy_d = 1'b0;
        if (start) begin
          acc_d   = bias_ext <<< FRC_BITS;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (addr_q == LAST) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 5'd1;
        end
      end
      S_DRAIN: state_d = S_ROUND;
      S_ROUND: begin
        y_d       = y_sat;
        y_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      v_q       <= 1'b0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      v_q       <= v_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign addr    = addr_q;
  assign busy    = busy_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - self-checking bench for neuron_mac, RELU=0 and RELU=1 side by side
// A dot-product reference model plus cycle timeline predicts addr/busy/y/y_valid.
module tb_neuron_mac;
  localparam int N = 28;

  logic        clk, rst, start;
  logic [12:0] bias, w_in, x_in;
  logic [4:0]  addr0, addr1;
  logic        busy0, busy1, yv0, yv1;
  logic [12:0] y0, y1;

  logic [12:0] wmem [32];
  logic [12:0] xmem [32];

  int checks = 0;
  int errors = 0;
  int npulse = 0;
  bit cmp_en = 0;

  neuron_mac #(.INT_BITS(6), .FRC_BITS(7), .N_INPUTS(N), .RELU(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .addr(addr0),
    .w_in(w_in), .x_in(x_in), .busy(busy0), .y(y0), .y_valid(yv0));

  neuron_mac #(.INT_BITS(6), .FRC_BITS(7), .N_INPUTS(N), .RELU(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .addr(addr1),
    .w_in(w_in), .x_in(x_in), .busy(busy1), .y(y1), .y_valid(yv1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_in <= wmem[addr0];
    x_in <= xmem[addr0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] model_dot(input logic [12:0] b, input bit relu);
    longint s;
    longint r;
    s = longint'($signed(b)) * 128;
    for (int k = 0; k < N; k++)
      s += longint'($signed(wmem[k])) * longint'($signed(xmem[k]));
    r = (s + 64) >>> 7;
    if (r > 4095) r = 4095;
    if (r < -4096) r = -4096;
    if (relu && r < 0) r = 0;
    return r[12:0];
  endfunction

  bit          m_act;
  int          m_cyc, m_acc, d, e_addr;
  bit          e_busy, e_yv;
  logic [12:0] e_y0, e_y1, p_y0, p_y1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_cyc = 0; m_acc = 0;
      e_busy = 0; e_addr = 0; e_yv = 0; e_y0 = '0; e_y1 = '0;
    end else begin
      m_cyc++;
      if (start && (!m_act || m_cyc - m_acc >= N + 3)) begin
        m_act = 1;
        m_acc = m_cyc;
        p_y0  = model_dot(bias, 1'b0);
        p_y1  = model_dot(bias, 1'b1);
      end
      e_busy = 0; e_addr = 0; e_yv = 0;
      if (m_act) begin
        d = m_cyc - m_acc;
        e_busy = (d <= N + 2);
        if (d <= N - 1) e_addr = d;
        if (d == N + 2) begin
          e_yv = 1;
          e_y0 = p_y0;
          e_y1 = p_y1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (yv0) npulse++;
    if (cmp_en) begin
      chk("addr0", 32'(addr0), 32'(e_addr));
      chk("addr1", 32'(addr1), 32'(e_addr));
      chk("busy0", 32'(busy0), 32'(e_busy));
      chk("busy1", 32'(busy1), 32'(e_busy));
      chk("y_valid0", 32'(yv0), 32'(e_yv));
      chk("y_valid1", 32'(yv1), 32'(e_yv));
      chk("y0", 32'(y0), 32'(e_y0));
      chk("y1", 32'(y1), 32'(e_y1));
    end
  end

  task automatic fill(input logic [12:0] w, input logic [12:0] x);
    for (int k = 0; k < 32; k++) begin
      wmem[k] = (k < N) ? w : 13'h0;
      xmem[k] = (k < N) ? x : 13'h0;
    end
  endtask

  task automatic run_one(input string name, input logic [12:0] b,
                         input logic [12:0] exp0, input logic [12:0] exp1);
    bias = b;
    chk({name, "_model0"}, 32'(model_dot(b, 1'b0)), 32'(exp0));
    chk({name, "_model1"}, 32'(model_dot(b, 1'b1)), 32'(exp1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 2) @(negedge clk);
    chk({name, "_valid"}, 32'(yv0), 32'd1);
    chk({name, "_y0"}, 32'(y0), 32'(exp0));
    chk({name, "_y1"}, 32'(y1), 32'(exp1));
    @(negedge clk);
  endtask

  int snap;

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0;
    fill(13'h0, 13'h0);
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_y", 32'(y0), 32'd0);
    chk("rst_valid", 32'(yv0), 32'd0);
    rst = 1'b0;
    cmp_en = 1;
    @(negedge clk);

    fill(13'h0080, 13'h0080);
    run_one("basic", 13'h0000, 13'h0E00, 13'h0E00);

    fill(13'h0400, 13'h0400);
    run_one("sat_pos", 13'h0000, 13'h0FFF, 13'h0FFF);
    fill(13'h1C00, 13'h0400);
    run_one("sat_neg", 13'h0000, 13'h1000, 13'h0000);

    fill(13'h0, 13'h0);
    wmem[0] = 13'h0040; xmem[0] = 13'h0001;
    run_one("rnd_pos", 13'h0000, 13'h0001, 13'h0001);
    wmem[0] = 13'h1FC0;
    run_one("rnd_neg", 13'h0000, 13'h0000, 13'h0000);

    fill(13'h0, 13'h0080);
    run_one("bias", 13'h1F80, 13'h1F80, 13'h0000);

    fill(13'h0080, 13'h0080);
    bias = 13'h0000;
    snap = npulse;
    start = 1'b1;
    repeat (3 * (N + 3)) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("hold_pulses", 32'(npulse - snap), 32'd3);

    snap = npulse;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 1 - 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun_pulses", 32'(npulse - snap), 32'd1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && addr0 != 5'd10; i++) @(negedge clk);
    chk("rst_wait_addr", 32'(addr0), 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_y", 32'(y0), 32'd0);
    chk("abort_addr", 32'(addr0), 32'd0);
    chk("abort_valid", 32'(yv0), 32'd0);
    chk("abort_y1", 32'(y1), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    snap = npulse;
    repeat (35) @(negedge clk);
    chk("abort_nopulse", 32'(npulse - snap), 32'd0);
    run_one("after_rst", 13'h0000, 13'h0E00, 13'h0E00);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
